io_bus_router: RTL and testbench

- Parametrised successor to the single-cycle RAM/IO decoder.
- Routes one CPU data-port transaction to the RAM or to one of N_SLOTS memory-mapped peripheral slots.
- Transactions are handshaked: request → select → wait for the target's ready → registered response.
- Sits between the core load/store unit and the RAM, UART, LED and GPIO blocks. Unmapped IO addresses return an error response instead of silently dropping.

---
 rtl/io_bus_router_pkg.sv | 31 +++
 rtl/io_bus_router_slot_decode.sv | 40 ++++
 rtl/io_bus_router.sv | 195 +++++++++++++++++++
 tb/tb_io_bus_router.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_router_pkg.sv
// ============================================================================
// io_bus_router_pkg : shared state encodings, default IO map and slot indices
// Revision 1.0
// ============================================================================
`default_nettype none

package io_bus_router_pkg;

    typedef enum logic [1:0] {
        IODEC_IDLE   = 2'd0,
        IODEC_ACCESS = 2'd1,
        IODEC_ERR    = 2'd2,
        IODEC_RESP   = 2'd3
    } iodec_state_e;

    localparam int          IODEC_IO_BIT_DFLT  = 22;
    localparam logic [31:0] IODEC_IO_BASE_DFLT = 32'h0040_0000;

    // Legacy fixed-decode peripherals, now expressed as slot numbers
    localparam int IODEC_SLOT_UART = 0;
    localparam int IODEC_SLOT_LED  = 1;
    localparam int IODEC_SLOT_GPIO = 2;

    function automatic logic [31:0] slot_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_bus_router_slot_decode.sv
// ============================================================================
// io_slot_decode : combinational address -> {RAM, unmapped, slot one-hot, offset}
// Revision 1.0
// ============================================================================
`default_nettype none

module io_slot_decode
    import io_bus_router_pkg::*;
#(
    parameter int          N_SLOTS = 4,
    parameter int          IO_BIT  = IODEC_IO_BIT_DFLT,
    parameter logic [31:0] IO_BASE = IODEC_IO_BASE_DFLT,
    parameter int          SLOT_AW = 8
) (
    input  logic [31:0]        addr,
    output logic               is_ram,
    output logic               is_unmapped,
    output logic [N_SLOTS-1:0] slot_oh,
    output logic [SLOT_AW-1:0] offset
);

    logic [31:0] off;
    logic [31:0] idx;

    always_comb begin
        // Wrapping subtraction turns IO addresses below IO_BASE into huge indices
        off         = slot_offset(addr, IO_BASE);
        idx         = off >> SLOT_AW;
        is_ram      = ~addr[IO_BIT];
        is_unmapped = addr[IO_BIT] && (idx >= 32'(N_SLOTS));
        offset      = off[SLOT_AW-1:0];
        slot_oh     = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            slot_oh[k] = addr[IO_BIT] && (idx == 32'(k));
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_bus_router.sv
// ============================================================================
// io_bus_router : handshaked CPU data-port router to RAM or N_SLOTS IO slots.
// Optional access timeout enabled by defining IODEC_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module io_bus_router
    import io_bus_router_pkg::*;
#(
    parameter int          N_SLOTS     = 4,
    parameter int          IO_BIT      = IODEC_IO_BIT_DFLT,
    parameter logic [31:0] IO_BASE     = IODEC_IO_BASE_DFLT,
    parameter int          SLOT_AW     = 8,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_err,
    output logic                  ram_sel,
    output logic                  ram_we,
    input  logic [31:0]           ram_rdata,
    input  logic                  ram_ready,
    output logic [N_SLOTS-1:0]    io_sel,
    output logic                  io_we,
    output logic [SLOT_AW-1:0]    io_addr,
    output logic [3:0]            io_be,
    output logic [31:0]           io_wdata,
    input  logic [N_SLOTS*32-1:0] io_rdata,
    input  logic [N_SLOTS-1:0]    io_ready
);

    if (N_SLOTS < 1 || N_SLOTS > 16) begin : g_bad_slots
        $error("io_bus_router: N_SLOTS out of range");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("io_bus_router: TIMEOUT_CYC out of range");
    end

    iodec_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic         we_q, we_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   be_q, be_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;

    logic [31:0]        dec_addr;
    logic               dec_is_ram;
    logic               dec_is_unmapped;
    logic [N_SLOTS-1:0] dec_slot_oh;
    logic [SLOT_AW-1:0] dec_offset;

    logic        in_access;
    logic        tgt_ready;
    logic [31:0] tgt_rdata;
    logic        io_rdy_sel;
    logic [31:0] io_rdata_sel;
    logic        timeout;

    // In IDLE the live request is decoded so the next state is known at once
    assign dec_addr = (state_q == IODEC_IDLE) ? cpu_addr : addr_q;

    io_slot_decode #(
        .N_SLOTS (N_SLOTS),
        .IO_BIT  (IO_BIT),
        .IO_BASE (IO_BASE),
        .SLOT_AW (SLOT_AW)
    ) u_decode (
        .addr        (dec_addr),
        .is_ram      (dec_is_ram),
        .is_unmapped (dec_is_unmapped),
        .slot_oh     (dec_slot_oh),
        .offset      (dec_offset)
    );

    always_comb begin
        io_rdy_sel   = |(io_ready & dec_slot_oh);
        io_rdata_sel = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (dec_slot_oh[k]) begin
                io_rdata_sel = io_rdata_sel | io_rdata[32*k +: 32];
            end
        end
        tgt_ready = dec_is_ram ? ram_ready : io_rdy_sel;
        tgt_rdata = dec_is_ram ? ram_rdata : io_rdata_sel;
    end

`ifdef IODEC_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYC > 255) ? 16 : 8;

    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        wait_d  = (state_q == IODEC_ACCESS) ? wait_q + 1'b1 : '0;
        timeout = (state_q == IODEC_ACCESS) && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IODEC_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    be_d    = cpu_be;
                    state_d = dec_is_unmapped ? IODEC_ERR : IODEC_ACCESS;
                end
            end
            IODEC_ACCESS: begin
                // Ready wins over a simultaneous timeout expiry
                if (tgt_ready) begin
                    rdata_d = we_q ? 32'h0 : tgt_rdata;
                    err_d   = 1'b0;
                    state_d = IODEC_RESP;
                end else if (timeout) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = IODEC_RESP;
                end
            end
            IODEC_ERR: begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
                state_d = IODEC_RESP;
            end
            IODEC_RESP: begin
                state_d = IODEC_IDLE;
            end
            default: begin
                state_d = IODEC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IODEC_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign in_access = (state_q == IODEC_ACCESS);
    assign ram_sel   = in_access & dec_is_ram;
    assign ram_we    = in_access & dec_is_ram & we_q;
    assign io_sel    = in_access ? dec_slot_oh : '0;
    assign io_we     = in_access & ~dec_is_ram & we_q;
    assign io_addr   = in_access ? dec_offset : '0;
    assign io_be     = in_access ? be_q : 4'h0;
    assign io_wdata  = in_access ? wdata_q : 32'h0;
    assign cpu_ready = (state_q == IODEC_RESP);
    assign cpu_err   = cpu_ready & err_q;
    assign cpu_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_router.sv
// ============================================================================
// tb_io_bus_router : directed, self-checking bench with a cycle-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_io_bus_router;

    localparam int N_SLOTS = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cpu_req = 1'b0;
    logic                  cpu_we = 1'b0;
    logic [31:0]           cpu_addr = '0;
    logic [31:0]           cpu_wdata = '0;
    logic [3:0]            cpu_be = '0;
    logic [31:0]           cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_err;
    logic                  ram_sel;
    logic                  ram_we;
    logic [31:0]           ram_rdata = '0;
    logic                  ram_ready = 1'b0;
    logic [N_SLOTS-1:0]    io_sel;
    logic                  io_we;
    logic [7:0]            io_addr;
    logic [3:0]            io_be;
    logic [31:0]           io_wdata;
    logic [N_SLOTS*32-1:0] io_rdata = '0;
    logic [N_SLOTS-1:0]    io_ready = '0;

    io_bus_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .ram_sel   (ram_sel),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_be     (io_be),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ready  (io_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
        logic        access;
        logic        io_tgt;
        logic        ram_sel;
        logic        ram_we;
        logic [3:0]  io_sel;
        logic        io_we;
        logic [7:0]  io_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit chk_en = 1'b0;

    int          sel_cnt = 0;
    int          last_lat = -1;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [7:0]  last_io_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // -1 = RAM, 0..N_SLOTS-1 = slot, 99 = unmapped
    function automatic int target_of(input logic [31:0] a);
        logic [31:0] off;
        if (a[22] == 1'b0) return -1;
        off = a - 32'h0040_0000;
        if (off < 32'(N_SLOTS * 256)) return int'(off / 256);
        return 99;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else cur = '{default: 0};
            chk("ram_sel", 32'(ram_sel), 32'(cur.ram_sel));
            chk("ram_we", 32'(ram_we), 32'(cur.ram_we));
            chk("io_sel", 32'(io_sel), 32'(cur.io_sel));
            chk("io_we", 32'(io_we), 32'(cur.io_we));
            chk("cpu_ready", 32'(cpu_ready), 32'(cur.rdy));
            if (cur.access) begin
                chk("io_wdata", io_wdata, cur.wdata);
                if (cur.io_tgt) begin
                    chk("io_addr", 32'(io_addr), 32'(cur.io_addr));
                    chk("io_be", 32'(io_be), 32'(cur.be));
                end
            end
            if (cur.rdy) begin
                chk("cpu_err", 32'(cpu_err), 32'(cur.err));
                chk("cpu_rdata", cpu_rdata, cur.rdata);
            end
            if (ram_sel || (io_sel != '0)) sel_cnt++;
            if (io_sel != '0) last_io_addr = io_addr;
            if (cpu_ready) begin
                last_lat   = cyc - start_cyc;
                last_rdata = cpu_rdata;
                last_err   = cpu_err;
            end
        end
    end

    // Drives one transaction from IDLE; the target readies after 'waits' stall cycles
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] data, input int waits,
                           input bit xtalk);
        int   t;
        exp_t e;
        t = target_of(addr);
        start_cyc = cyc;
        sel_cnt   = 0;
        last_lat  = -1;
        e = '{default: 0};
        exp_q.push_back(e);
        if (t == 99) begin
            exp_q.push_back(e);
            e.rdy = 1; e.err = 1; e.rdata = 32'h0;
            exp_q.push_back(e);
        end else begin
            e.access  = 1;
            e.io_tgt  = (t >= 0);
            e.ram_sel = (t < 0);
            e.ram_we  = (t < 0) && we;
            e.io_sel  = (t >= 0) ? (4'b0001 << t) : 4'b0000;
            e.io_we   = (t >= 0) && we;
            e.io_addr = 8'(addr - 32'h0040_0000);
            e.be      = be;
            e.wdata   = wdata;
            for (int i = 0; i <= waits; i++) exp_q.push_back(e);
            e = '{default: 0};
            e.rdy = 1; e.err = 0; e.rdata = we ? 32'h0 : data;
            exp_q.push_back(e);
        end
        for (int k = 0; k < N_SLOTS; k++) io_rdata[32*k +: 32] = 32'hFFFF_FFFF;
        if (t >= 0 && t < N_SLOTS) io_rdata[32*t +: 32] = data;
        ram_rdata = (t < 0) ? data : 32'hDEAD_BEEF;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_be = ~be;
        if (t == 99) begin
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i <= waits; i++) begin
                if (t < 0) ram_ready = (i == waits);
                else io_ready[t] = (i == waits);
                if (xtalk && t != 0) io_ready[0] = (i == 0);
                @(posedge clk); #1;
            end
        end
        ram_ready = 1'b0;
        io_ready  = '0;
        // A request raised during RESP must not start a transaction
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0040;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_ctrl", 32'({cpu_ready, cpu_err, ram_sel, ram_we, io_sel, io_we, io_addr, io_be}), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_wdata", io_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 0, 1'b0);
        chk("ram_ld_lat", 32'(last_lat), 32'd2);
        chk("ram_ld_rdata", last_rdata, 32'h1234_5678);
        chk("ram_ld_err", 32'(last_err), 32'd0);
        chk("ram_ld_selcyc", 32'(sel_cnt), 32'd1);

        run_txn(32'h0040_0204, 1'b1, 32'h0000_00A5, 4'hF, 32'h5555_AAAA, 3, 1'b0);
        chk("io_st_lat", 32'(last_lat), 32'd5);
        chk("io_st_selcyc", 32'(sel_cnt), 32'd4);
        chk("io_st_addr", 32'(last_io_addr), 32'h04);
        chk("io_st_rdata", last_rdata, 32'h0);

        run_txn(32'h0040_0400, 1'b0, 32'h0, 4'hF, 32'h7777_7777, 0, 1'b0);
        chk("unmap_lat", 32'(last_lat), 32'd2);
        chk("unmap_err", 32'(last_err), 32'd1);
        chk("unmap_selcyc", 32'(sel_cnt), 32'd0);
        chk("unmap_rdata", last_rdata, 32'h0);

        run_txn(32'h0040_0110, 1'b0, 32'h0, 4'hF, 32'hCAFE_0001, 2, 1'b1);
        chk("xtalk_rdata", last_rdata, 32'hCAFE_0001);
        chk("xtalk_lat", 32'(last_lat), 32'd4);

        run_txn(32'h0000_0100, 1'b1, 32'hDEAD_0042, 4'b0011, 32'h0, 1, 1'b0);
        run_txn(32'h8040_0000, 1'b1, 32'h1111_2222, 4'hF, 32'h0, 0, 1'b0);
        chk("wrap_err", 32'(last_err), 32'd1);
        run_txn(32'h0040_03FF, 1'b0, 32'h0, 4'b1000, 32'h0BAD_F00D, 0, 1'b0);
        chk("slot3_addr", 32'(last_io_addr), 32'hFF);

        // Reset in the middle of a slot-1 access
        chk_en = 1'b0;
        io_ready = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0040_0100; cpu_be = 4'hF;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst_sel", 32'(io_sel), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({cpu_ready, cpu_err, ram_sel, ram_we, io_sel, io_we, io_addr, io_be}), 32'h0);
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_wdata", io_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run_txn(32'h0040_0008, 1'b0, 32'h0, 4'hF, 32'h0000_BEEF, 1, 1'b0);
        chk("post_rst_rdata", last_rdata, 32'h0000_BEEF);
        chk("post_rst_lat", 32'(last_lat), 32'd3);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
